temp_buffer_arbiter: RTL

//   Shares the 4-entry single-port temp buffer (registered read data) between two

---
 rtl/temp_buffer_arbiter_if.sv | 16 +
 rtl/temp_buffer_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/temp_buffer_arbiter_if.sv
// rtl/temp_buffer_arbiter_if.sv - requester-side access port of the temp buffer arbiter
interface temp_buffer_arbiter_if #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 2
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/temp_buffer_arbiter.sv
// rtl/temp_buffer_arbiter.sv - round-robin sharing of the single-port temp buffer between A and B
// Zero-fills the buffer after reset, then grants one access per cycle and routes read data back.
module temp_buffer_arbiter #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  temp_buffer_arbiter_if.slave port_a,
  temp_buffer_arbiter_if.slave port_b,
  output logic                init_done,
  output logic                temp_write,
  output logic [ADDR_W-1:0]   temp_address,
  output logic [DATA_W-1:0]   temp_in,
  input  logic [DATA_W-1:0]   temp_out
);

  localparam logic [0:0]        ST_INIT  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_b;
  logic              rd_pend;
  logic              rd_owner_b;
  logic              grant_a;
  logic              grant_b;
  logic              rvalid_a;
  logic              rvalid_b;

  // rr_b set means B wins the next contended cycle
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && state == ST_RUN) begin
      if (port_a.req && port_b.req) begin
        grant_a = !rr_b;
        grant_b = rr_b;
      end else begin
        grant_a = port_a.req;
        grant_b = port_b.req;
      end
    end
  end

  always_comb begin
    temp_write   = 1'b0;
    temp_address = '0;
    temp_in      = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        temp_write   = 1'b1;
        temp_address = init_cnt;
      end else if (grant_a) begin
        temp_write   = port_a.we;
        temp_address = port_a.addr;
        temp_in      = port_a.wdata;
      end else if (grant_b) begin
        temp_write   = port_b.we;
        temp_address = port_b.addr;
        temp_in      = port_b.wdata;
      end
    end
  end

  assign init_done = !rst && (state == ST_RUN);

  // the buffer returns data one cycle after the address, so the owner tag lives one cycle
  assign rvalid_a = !rst && rd_pend && !rd_owner_b;
  assign rvalid_b = !rst && rd_pend && rd_owner_b;

  assign port_a.gnt    = grant_a;
  assign port_b.gnt    = grant_b;
  assign port_a.rvalid = rvalid_a;
  assign port_b.rvalid = rvalid_b;
  assign port_a.rdata  = rvalid_a ? temp_out : '0;
  assign port_b.rdata  = rvalid_b ? temp_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      rr_b       <= 1'b0;
      rd_pend    <= 1'b0;
      rd_owner_b <= 1'b0;
    end else begin
      rd_pend    <= (grant_a && !port_a.we) || (grant_b && !port_b.we);
      rd_owner_b <= grant_b;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == CNT_LAST) begin
          state <= ST_RUN;
        end
      end else if (grant_a || grant_b) begin
        rr_b <= grant_a;
      end
    end
  end

endmodule
